jtkcpu_divx: RTL and testbench



---
 rtl/jtkcpu_pkg.sv | 14 +
 rtl/jtkcpu_div.sv | 60 ++++++
 rtl/jtkcpu_divx.sv | 119 +++++++++++
 tb/tb_jtkcpu_divx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkcpu_pkg.sv
// Shared KCPU definitions: divide sequencer state encoding and divide-by-zero constants.
package jtkcpu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        ARM   = 3'd2,
        WAIT  = 3'd3,
        WB    = 3'd4
    } div_state_t;

    localparam logic [7:0] DZ_QUOT = 8'hFF;

endpackage

// File: rtl/jtkcpu_div.sv
// Iterative 16/8 restoring divider, one quotient bit per cen cycle, 16 busy cycles.
// Signed mode divides magnitudes; the quotient truncates toward zero and the remainder takes the dividend sign.
module jtkcpu_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        start,
    input  logic        sign,
    input  logic        len,
    input  logic [15:0] op0,
    input  logic [7:0]  op1,
    output logic [7:0]  quot,
    output logic [7:0]  rem,
    output logic        busy,
    output logic        v
);
    logic [15:0] dvd, abs_n, q;
    logic [7:0]  abs_d, d, r, sub;
    logic [8:0]  t;
    logic [4:0]  cnt;
    logic        ge, neg_q, neg_r, sgn_l;

    // An 8-bit signed dividend lives in op0[7:0] and must be sign-extended here
    assign dvd   = (sign && !len) ? {{8{op0[7]}}, op0[7:0]} : op0;
    assign abs_n = (sign && dvd[15]) ? (~dvd + 16'd1) : dvd;
    assign abs_d = (sign && op1[7]) ? (~op1 + 8'd1) : op1;

    assign t   = {r, q[15]};
    assign ge  = t >= {1'b0, d};
    assign sub = t[7:0] - d;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0; r <= '0; d <= '0; cnt <= '0;
            busy <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0; sgn_l <= 1'b0;
        end else if (cen) begin
            if (start) begin
                q     <= abs_n;
                r     <= '0;
                d     <= abs_d;
                cnt   <= 5'd16;
                busy  <= 1'b1;
                sgn_l <= sign;
                neg_q <= sign & (dvd[15] ^ op1[7]);
                neg_r <= sign & dvd[15];
            end else if (busy) begin
                q   <= {q[14:0], ge};
                r   <= ge ? sub : t[7:0];
                cnt <= cnt - 5'd1;
                if (cnt == 5'd1) busy <= 1'b0;
            end
        end
    end

    assign quot = neg_q ? (~q[7:0] + 8'd1) : q[7:0];
    assign rem  = neg_r ? (~r + 8'd1) : r;
    // Negative results may reach -128, positive ones only +127
    assign v    = sgn_l ? (neg_q ? (q > 16'd128) : (q > 16'd127)) : (q[15:8] != 8'd0);

endmodule

// File: rtl/jtkcpu_divx.sv
// DIVX/DIV sequencer: latches operands, starts jtkcpu_div once, writes results back in one cycle.
// Define JTKCPU_DIVZERO_TRAP_EN to trap on divide-by-zero instead of writing a saturated result.
module jtkcpu_divx
    import jtkcpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        req,
    input  logic        len,
    input  logic        sgn,
    input  logic [15:0] x_in,
    input  logic [7:0]  b_in,
    output logic [15:0] x_out,
    output logic [7:0]  a_out,
    output logic        we_x,
    output logic        we_a,
    output logic        flag_we,
    output logic        z,
    output logic        n,
    output logic        v,
    output logic        done,
    output logic        halt,
    output logic        dz_trap
);
    div_state_t  state;
    logic [15:0] op0;
    logic [7:0]  op1, quot, rem;
    logic        len_l, sgn_l, start, busy, div_v, done_r, we_r;

    assign start = (state == ISSUE);

    jtkcpu_div u_div (
        .clk   (clk),
        .rst   (rst),
        .cen   (cen),
        .start (start),
        .sign  (sgn_l),
        .len   (len_l),
        .op0   (op0),
        .op1   (op1),
        .quot  (quot),
        .rem   (rem),
        .busy  (busy),
        .v     (div_v)
    );

`ifdef JTKCPU_DIVZERO_TRAP_EN
    logic dz_r;
    assign dz_trap = dz_r & cen;
`else
    assign dz_trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op0 <= '0; op1 <= '0; len_l <= 1'b0; sgn_l <= 1'b0;
            done_r <= 1'b0; we_r <= 1'b0;
            x_out <= '0; a_out <= '0; z <= 1'b0; n <= 1'b0; v <= 1'b0;
`ifdef JTKCPU_DIVZERO_TRAP_EN
            dz_r <= 1'b0;
`endif
        end else if (cen) begin
            case (state)
                IDLE: if (req) begin
                    op0   <= len ? x_in : {8'd0, x_in[7:0]};
                    op1   <= b_in;
                    len_l <= len;
                    sgn_l <= sgn;
                    if (b_in == 8'd0) begin
                        state  <= WB;
                        done_r <= 1'b1;
`ifdef JTKCPU_DIVZERO_TRAP_EN
                        dz_r   <= 1'b1;
`else
                        we_r   <= 1'b1;
                        x_out  <= {8'd0, DZ_QUOT};
                        a_out  <= x_in[7:0];
                        v <= 1'b1; z <= 1'b0; n <= 1'b1;
`endif
                    end else begin
                        state <= ISSUE;
                    end
                end
                ISSUE: state <= ARM;
                // busy is not yet trustworthy on the cycle right after start
                ARM:   state <= WAIT;
                WAIT: if (!busy) begin
                    state  <= WB;
                    done_r <= 1'b1;
                    we_r   <= 1'b1;
                    x_out  <= {{8{sgn_l & quot[7]}}, quot};
                    a_out  <= rem;
                    z      <= (quot == 8'd0);
                    n      <= quot[7];
                    v      <= div_v;
                end
                WB: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                    we_r   <= 1'b0;
`ifdef JTKCPU_DIVZERO_TRAP_EN
                    dz_r   <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes gated by cen so a frozen WB cycle still writes only once
    assign done    = done_r & cen;
    assign we_x    = we_r & cen;
    assign we_a    = we_r & cen;
    assign flag_we = we_r & cen;
    assign halt    = (state != IDLE);

endmodule

// File: tb/tb_jtkcpu_divx.sv
// Directed and random checks of jtkcpu_divx against hand-computed and arithmetic expectations.
module tb_jtkcpu_divx;
    logic        clk, rst, cen, req, len, sgn;
    logic [15:0] x_in, x_out;
    logic [7:0]  b_in, a_out;
    logic        we_x, we_a, flag_we, z, n, v, done, halt, dz_trap;

    int total = 0;
    int bad   = 0;
    int lat8  = 18;

    int          r_lat, r_ndone, r_nstart, r_nwe;
    logic [15:0] r_xo;
    logic [7:0]  r_ao;
    logic        r_z, r_n, r_v, r_we, r_fwe, r_dz, r_halt1;

    jtkcpu_divx dut (
        .clk(clk), .rst(rst), .cen(cen), .req(req), .len(len), .sgn(sgn),
        .x_in(x_in), .b_in(b_in), .x_out(x_out), .a_out(a_out),
        .we_x(we_x), .we_a(we_a), .flag_we(flag_we), .z(z), .n(n), .v(v),
        .done(done), .halt(halt), .dz_trap(dz_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request and records what the DUT shows at its first done pulse
    task automatic do_op(input logic [15:0] x, input logic [7:0] b, input logic l,
                         input logic s, input int cmode);
        r_lat = -1; r_ndone = 0; r_nstart = 0; r_nwe = 0;
        x_in = x; b_in = b; len = l; sgn = s; req = 1'b1; cen = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req = 1'b0; r_halt1 = halt;
                x_in = ~x; b_in = ~b; len = ~l; sgn = ~s;
            end
            if (dut.start === 1'b1 && cen) r_nstart++;
            if (we_x === 1'b1) r_nwe++;
            if (done === 1'b1) begin
                r_ndone++;
                if (r_lat < 0) begin
                    r_lat = i; r_xo = x_out; r_ao = a_out;
                    r_z = z; r_n = n; r_v = v; r_we = we_x; r_fwe = flag_we; r_dz = dz_trap;
                end
            end
            if (r_lat >= 0 && i >= r_lat + 4) break;
            cen = (cmode == 1) ? (i % 3 == 0) : 1'b1;
        end
        cen = 1'b1;
        total++;
        if (r_lat < 0) begin bad++; $display("FAIL timeout: no done for x=%h b=%h", x, b); end
    endtask

    task automatic test_reset;
        rst = 1'b1; cen = 1'b1; req = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({x_out, a_out} !== 24'h0) begin bad++; $display("FAIL reset_data: got %h/%h want 0", x_out, a_out); end
        total++;
        if ({we_x, we_a, flag_we, z, n, v, done, halt, dz_trap} !== 9'h0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0", {we_x, we_a, flag_we, z, n, v, done, halt, dz_trap});
        end
        rst = 1'b0;
    endtask

    task automatic test_div8;
        do_op(16'd125, 8'd7, 1'b0, 1'b0, 0);
        lat8 = r_lat;
        total++;
        if (r_xo !== 16'h0011) begin bad++; $display("FAIL div8_x: got %h want 0011", r_xo); end
        total++;
        if (r_ao !== 8'h06) begin bad++; $display("FAIL div8_a: got %h want 06", r_ao); end
        total++;
        if ({r_z, r_n, r_v, r_we, r_fwe} !== 5'b00011) begin
            bad++; $display("FAIL div8_flags: got %b want 00011", {r_z, r_n, r_v, r_we, r_fwe});
        end
        total++;
        if (r_ndone !== 1 || r_nstart !== 1) begin
            bad++; $display("FAIL div8_pulses: done=%0d start=%0d want 1/1", r_ndone, r_nstart);
        end
        total++;
        if (r_halt1 !== 1'b1 || r_lat < 4 || r_lat > 30) begin
            bad++; $display("FAIL div8_timing: halt=%b lat=%0d want 1, 4..30", r_halt1, r_lat);
        end
    endtask

    task automatic test_div16;
        do_op(16'h1234, 8'h56, 1'b1, 1'b0, 0);
        total++;
        if ({r_xo, r_ao} !== 24'h0036_10) begin bad++; $display("FAIL div16_res: got %h/%h want 0036/10", r_xo, r_ao); end
        total++;
        if ({r_z, r_n, r_v} !== 3'b000 || r_lat !== lat8) begin
            bad++; $display("FAIL div16_flags: got %b lat=%0d want 000 lat=%0d", {r_z, r_n, r_v}, r_lat, lat8);
        end
    endtask

    task automatic test_signed;
        // -7 / 2 = -3 remainder -1
        do_op(16'h00F9, 8'd2, 1'b0, 1'b1, 0);
        total++;
        if ({r_xo, r_ao} !== 24'hFFFD_FF) begin bad++; $display("FAIL signed_res: got %h/%h want FFFD/FF", r_xo, r_ao); end
        total++;
        if ({r_z, r_n, r_v} !== 3'b010) begin bad++; $display("FAIL signed_flags: got %b want 010", {r_z, r_n, r_v}); end
    endtask

    task automatic test_overflow;
        do_op(16'h4000, 8'd2, 1'b1, 1'b0, 0);
        total++;
        if (r_v !== 1'b1 || r_fwe !== 1'b1) begin bad++; $display("FAIL ovf: v=%b flag_we=%b want 1/1", r_v, r_fwe); end
    endtask

    task automatic test_divzero;
        do_op(16'h0042, 8'd0, 1'b1, 1'b0, 0);
        total++;
        if (r_lat !== 1 || r_nstart !== 0 || r_ndone !== 1) begin
            bad++; $display("FAIL dz_timing: lat=%0d start=%0d done=%0d want 1/0/1", r_lat, r_nstart, r_ndone);
        end
`ifdef JTKCPU_DIVZERO_TRAP_EN
        total++;
        if (r_dz !== 1'b1 || r_nwe !== 0 || r_fwe !== 1'b0) begin
            bad++; $display("FAIL dz_trap: trap=%b writes=%0d fwe=%b want 1/0/0", r_dz, r_nwe, r_fwe);
        end
`else
        total++;
        if ({r_xo, r_ao} !== 24'h00FF_42) begin bad++; $display("FAIL dz_res: got %h/%h want 00FF/42", r_xo, r_ao); end
        total++;
        if ({r_z, r_n, r_v, r_we, r_dz} !== 5'b01110) begin
            bad++; $display("FAIL dz_flags: got %b want 01110", {r_z, r_n, r_v, r_we, r_dz});
        end
`endif
    endtask

    task automatic test_back_to_back;
        int d1, d2, nd, bad_x;
        d1 = -1; d2 = -1; nd = 0; bad_x = 0;
        x_in = 16'd125; b_in = 8'd7; len = 1'b0; sgn = 1'b0; req = 1'b1; cen = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                nd++;
                if (x_out !== 16'h0011) bad_x++;
                if (d1 < 0) d1 = i; else if (d2 < 0) d2 = i;
            end
        end
        req = 1'b0;
        repeat (30) @(negedge clk);
        total++;
        if (d1 !== lat8 || d2 - d1 !== lat8 + 1 || bad_x !== 0) begin
            bad++; $display("FAIL b2b_spacing: d1=%0d d2=%0d badx=%0d want %0d/%0d/0", d1, d2, bad_x, lat8, 2 * lat8 + 1);
        end
        total++;
        if (nd !== (80 - lat8) / (lat8 + 1) + 1) begin
            bad++; $display("FAIL b2b_count: got %0d want %0d", nd, (80 - lat8) / (lat8 + 1) + 1);
        end
    endtask

    task automatic test_rst_wait;
        int nd;
        nd = 0;
        x_in = 16'd200; b_in = 8'd3; len = 1'b0; sgn = 1'b0; req = 1'b1; cen = 1'b1;
        @(negedge clk); req = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (halt !== 1'b0 || done !== 1'b0 || x_out !== 16'h0) begin
            bad++; $display("FAIL rst_wait: halt=%b done=%b x=%h want 0/0/0000", halt, done, x_out);
        end
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1 || we_x === 1'b1) nd++;
        end
        total++;
        if (nd !== 0) begin bad++; $display("FAIL rst_nowb: strobes=%0d want 0", nd); end
        do_op(16'd200, 8'd3, 1'b0, 1'b0, 0);
        total++;
        if ({r_xo, r_ao} !== 24'h0042_02) begin bad++; $display("FAIL rst_recover: got %h/%h want 0042/02", r_xo, r_ao); end
    endtask

    task automatic test_cen_toggle;
        do_op(16'd125, 8'd7, 1'b0, 1'b0, 1);
        total++;
        if ({r_xo, r_ao} !== 24'h0011_06) begin bad++; $display("FAIL cen_res: got %h/%h want 0011/06", r_xo, r_ao); end
        total++;
        if (r_ndone !== 1 || r_nwe !== 1 || r_nstart !== 1) begin
            bad++; $display("FAIL cen_pulses: done=%0d we=%0d start=%0d want 1/1/1", r_ndone, r_nwe, r_nstart);
        end
    endtask

    task automatic test_random;
        logic [15:0] x, exo;
        logic [7:0]  b, exa;
        logic        l, s, ev;
        int          dvd, dv, q, r;
        for (int it = 0; it < 2048; it++) begin
            x = 16'($urandom); b = 8'($urandom_range(1, 255));
            l = 1'($urandom); s = 1'($urandom);
            if (s) begin
                dvd = l ? int'($signed(x)) : int'($signed(x[7:0]));
                dv  = int'($signed(b));
                q = dvd / dv; r = dvd % dv;
                ev = (q > 127) || (q < -128);
            end else begin
                dvd = l ? int'(x) : int'(x[7:0]);
                dv  = int'(b);
                q = dvd / dv; r = dvd - dv * q;
                ev = (q > 255);
            end
            exo = 16'(q); exa = 8'(r);
            do_op(x, b, l, s, 0);
            total++;
            if (r_v !== ev) begin bad++; $display("FAIL rnd_v: x=%h b=%h l=%b s=%b got %b want %b", x, b, l, s, r_v, ev); end
            if (!ev) begin
                total++;
                if ({r_xo, r_ao} !== {exo, exa}) begin
                    bad++; $display("FAIL rnd_res: x=%h b=%h l=%b s=%b got %h/%h want %h/%h", x, b, l, s, r_xo, r_ao, exo, exa);
                end
                total++;
                if ({r_z, r_n} !== {exo[7:0] == 8'd0, exo[7]}) begin
                    bad++; $display("FAIL rnd_zn: x=%h b=%h got %b want %b", x, b, {r_z, r_n}, {exo[7:0] == 8'd0, exo[7]});
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; req = 1'b0; len = 1'b0; sgn = 1'b0; x_in = '0; b_in = '0;
        test_reset;
        test_div8;
        test_div16;
        test_signed;
        test_overflow;
        test_divzero;
        test_back_to_back;
        test_rst_wait;
        test_cen_toggle;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
